// File: rtl/shift_stage_if.sv
// Handshake bundle for the two-stage shifter.
// Upstream op/operand channel plus downstream result channel.
interface shift_stage_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] in;
  logic [AMT_W-1:0] num;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, op, in, num, out_ready,
    input  in_ready, out_valid, out, carry, zero
  );

  modport slave (
    input  in_valid, op, in, num, out_ready,
    output in_ready, out_valid, out, carry, zero
  );
endinterface

// File: rtl/shift_stage.sv
// Two-stage barrel shifter: S1 latches the request,
// S2 holds the registered result, carry and zero flag.
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  shift_stage_if.slave bus
);

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] n;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
  } s2_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;

  logic in_fire;
  logic out_fire;
  logic s2_adv;

  logic             is_lsl, is_lsr;
  logic             is_asr, is_ror;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic [2*WIDTH-1:0] dbl;

  assign out_fire    = s2_vld_q & bus.out_ready;
  assign s2_adv      = s1_vld_q & (~s2_vld_q | bus.out_ready);
  assign bus.in_ready = ~s1_vld_q | s2_adv;
  assign in_fire     = bus.in_valid & bus.in_ready;

  assign is_lsl = (s1_q.op == 2'b00);
  assign is_lsr = (s1_q.op == 2'b01);
  assign is_asr = (s1_q.op == 2'b10);
  assign is_ror = (s1_q.op == 2'b11);

  // Widen by one bit so the shifted-out bit lands in cy; num==0 yields 0.
  always_comb begin
    res = '0;
    cy  = 1'b0;
    dbl = {s1_q.a, s1_q.a} >> s1_q.n;
    unique case (1'b1)
      is_lsl: {cy, res} = {1'b0, s1_q.a} << s1_q.n;
      is_lsr: {res, cy} = {s1_q.a, 1'b0} >> s1_q.n;
      is_asr: {res, cy} = $signed({s1_q.a, 1'b0}) >>> s1_q.n;
      is_ror: begin
        res = dbl[WIDTH-1:0];
        cy  = (s1_q.n != '0) & res[WIDTH-1];
      end
      default: begin
        res = '0;
        cy  = 1'b0;
      end
    endcase
  end

  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = s1_vld_q & ~s2_adv;
    if (in_fire) begin
      s1_d.op  = bus.op;
      s1_d.a   = bus.in;
      s1_d.n   = bus.num;
      s1_vld_d = 1'b1;
    end
  end

  always_comb begin
    s2_d     = s2_q;
    s2_vld_d = s2_vld_q & ~out_fire;
    if (s2_adv) begin
      s2_d.res = res;
      s2_d.c   = cy;
      s2_d.z   = (res == '0);
      s2_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      s2_q     <= s2_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.out       = s2_q.res;
  assign bus.carry     = s2_q.c;
  assign bus.zero      = s2_q.z;

endmodule

// File: tb/tb_shift_stage.sv
// Bench for shift_stage: directed table, stall/reset
// sequences and random traffic against a 64-bit model.
module tb_shift_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_stage_if #(.WIDTH(32), .AMT_W(5)) bus ();

  shift_stage #(.WIDTH(32), .AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  typedef struct {
    logic [31:0] o;
    logic        c;
    logic        z;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  n;
    logic [31:0] eo;
    logic        ec;
    logic        ez;
  } vec_t;

  res_t exp_q[$];

  function automatic res_t model(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input int n);
    logic [63:0] t;
    res_t r;
    r.o = '0;
    r.c = 1'b0;
    case (op)
      2'd0: begin
        t = {32'b0, a} << n;
        r.o = t[31:0];
        r.c = (n == 0) ? 1'b0 : t[32];
      end
      2'd1: begin
        t = {a, 32'b0} >> n;
        r.o = t[63:32];
        r.c = (n == 0) ? 1'b0 : t[31];
      end
      2'd2: begin
        t = 64'($signed({a, 32'b0}) >>> n);
        r.o = t[63:32];
        r.c = (n == 0) ? 1'b0 : t[31];
      end
      default: begin
        for (int i = 0; i < 32; i++)
          r.o[i] = a[(i + n) % 32];
        r.c = (n == 0) ? 1'b0 : r.o[31];
      end
    endcase
    r.z = (r.o == 32'h0);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] op,
                       input logic [31:0] a, input logic [4:0] n,
                       input logic ordy);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.op        = op;
    bus.in        = a;
    bus.num       = n;
    bus.out_ready = ordy;
  endtask

  // Called at a negedge: check S2 against the queue head, then
  // record what will transfer on the coming rising edge.
  task automatic observe();
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_result", 32'd1, 32'd0);
      end else begin
        chk("sb_out", bus.out, exp_q[0].o);
        chk("sb_carry", bus.carry, exp_q[0].c);
        chk("sb_zero", bus.zero, exp_q[0].z);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.op, bus.in, int'(bus.num)));
  endtask

  task automatic step(input logic iv, input logic [1:0] op,
                      input logic [31:0] a, input logic [4:0] n,
                      input logic ordy);
    drive(iv, op, a, n, ordy);
    @(negedge clk);
    observe();
  endtask

  vec_t tbl[12];
  logic [1:0]  sop[8];
  logic [31:0] sa[8];
  logic [4:0]  sn[8];

  initial begin
    tbl[0]  = '{2'd1, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
    tbl[1]  = '{2'd2, 32'hF0000000, 5'd4,  32'hFF000000, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 32'h80000001, 5'd1,  32'h00000002, 1'b1, 1'b0};
    tbl[3]  = '{2'd3, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 1'b0};
    tbl[4]  = '{2'd0, 32'h1234ABCD, 5'd0,  32'h1234ABCD, 1'b0, 1'b0};
    tbl[5]  = '{2'd1, 32'h1234ABCD, 5'd0,  32'h1234ABCD, 1'b0, 1'b0};
    tbl[6]  = '{2'd2, 32'h1234ABCD, 5'd0,  32'h1234ABCD, 1'b0, 1'b0};
    tbl[7]  = '{2'd3, 32'h1234ABCD, 5'd0,  32'h1234ABCD, 1'b0, 1'b0};
    tbl[8]  = '{2'd1, 32'h0000000F, 5'd4,  32'h00000000, 1'b1, 1'b1};
    tbl[9]  = '{2'd0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
    tbl[10] = '{2'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[11] = '{2'd3, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.in        = '0;
    bus.num       = '0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out", bus.out, 32'h0);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_zero", bus.zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].n, 1'b1);
      @(negedge clk);
      chk($sformatf("t%0d_in_ready", i), bus.in_ready, 1'b1);
      drive(1'b0, 2'd0, 32'h0, 5'd0, 1'b1);
      @(negedge clk);
      chk($sformatf("t%0d_lat1", i), bus.out_valid, 1'b0);
      @(negedge clk);
      chk($sformatf("t%0d_lat2", i), bus.out_valid, 1'b1);
      chk($sformatf("t%0d_out", i), bus.out, tbl[i].eo);
      chk($sformatf("t%0d_carry", i), bus.carry, tbl[i].ec);
      chk($sformatf("t%0d_zero", i), bus.zero, tbl[i].ez);
    end
    step(1'b0, 2'd0, 32'h0, 5'd0, 1'b1);

    // Eight back-to-back ops with a four-cycle downstream stall.
    begin
      int idx;
      int c;
      logic blocked;
      idx = 0;
      blocked = 1'b0;
      n_pop = 0;
      for (int k = 0; k < 8; k++) begin
        sop[k] = 2'($urandom_range(0, 3));
        sa[k]  = $urandom;
        sn[k]  = 5'($urandom_range(0, 31));
      end
      for (c = 0; c < 40; c++) begin
        logic iv;
        logic fire;
        iv = (idx < 8);
        drive(iv, iv ? sop[idx] : 2'd0, iv ? sa[idx] : 32'h0,
              iv ? sn[idx] : 5'd0, !(c >= 3 && c < 7));
        @(negedge clk);
        fire = iv && bus.in_ready;
        if (iv && !bus.in_ready)
          blocked = 1'b1;
        observe();
        if (fire)
          idx++;
        if (idx == 8 && exp_q.size() == 0)
          break;
      end
      chk("stall_in_ready_fell", blocked, 1'b1);
      chk("stall_accepted", idx, 8);
      chk("stall_emitted", n_pop, 8);
    end

    for (int k = 0; k < 500; k++) begin
      logic [4:0] n;
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0: n = 5'd0;
        1: n = 5'd31;
        default: n = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'h0;
        default: a = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           a, n, $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      step(1'b0, 2'd0, 32'h0, 5'd0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    // Fill both stages, then reset mid-flight.
    step(1'b1, 2'd1, 32'hDEADBEEF, 5'd3, 1'b0);
    step(1'b1, 2'd0, 32'h0000FFFF, 5'd8, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out", bus.out, 32'h0);
    chk("mid_rst_carry", bus.carry, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    exp_q.delete();
    bus.in_valid  = 1'b1;
    bus.op        = 2'd0;
    bus.in        = 32'h00000001;
    bus.num       = 5'd4;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 5'd0, 1'b1);
    @(negedge clk);
    chk("post_rst_no_stale", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("first_xfer_valid", bus.out_valid, 1'b1);
    chk("first_xfer_out", bus.out, 32'h00000010);
    chk("first_xfer_carry", bus.carry, 1'b0);
    @(negedge clk);
    chk("post_rst_idle", bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; only 32 is supported.
REQ-002 Parameter AMT_W, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream presents an operation this cycle.
REQ-006 in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 op  input  2  shift kind: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 in  input  WIDTH  operand to shift.
REQ-009 num  input  AMT_W  shift amount, 0..31.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready at a rising edge.
REQ-012 out  output  WIDTH  registered shift result.
REQ-013 carry  output  1  registered last bit shifted out.
REQ-014 zero  output  1  registered flag, 1 when out == 0.

Function
REQ-015 Two register stages SHALL exist: S1 captures op/in/num; S2 holds out/carry/zero; each stage has its own valid bit.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid assertion when out_ready is held high.
REQ-017 Throughput SHALL be one operation per cycle when out_ready is held high; no bubbles inserted.
REQ-018 S2 SHALL load from S1 when S1 valid and (S2 empty or S2 transferring this cycle).
REQ-019 in_ready SHALL be 1 when S1 empty or S1 advancing into S2 this cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 When out_valid && !out_ready, out/carry/zero SHALL hold stable and in_ready SHALL fall once S1 is also full.
REQ-021 Simultaneous input transfer and S1->S2 advance SHALL keep S1 valid with the new operand; no loss or duplication.
REQ-022 LSL: out = in << num, zero-filled; carry = in[32-num].
REQ-023 LSR: out = in >> num, zero-filled; carry = in[num-1].
REQ-024 ASR: out = in >> num, filled with in[31]; carry = in[num-1].
REQ-025 ROR: out = in rotated right by num; carry = out[31].
REQ-026 num == 0, any op: out = in, carry = 0.
REQ-027 num == 31 SHALL be exact: LSR of 0x80000000 gives 0x00000001; no amount is truncated or aliased.
REQ-028 zero SHALL be computed from the same result written to out, in the same cycle.
REQ-029 Ops and values never accepted (in_valid low) SHALL not alter any state.

Reset
REQ-030 rst_n low SHALL immediately clear both valid bits, out = 0x00000000, carry = 0, zero = 0, independent of clk.
REQ-031 in_ready SHALL be 1 during and after reset; out_valid SHALL be 0.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none appears after release.
REQ-033 First transfer SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-034 LSR, in=0x80000000, num=31, out_ready=1 -> two cycles later out=0x00000001, carry=0, zero=0.
REQ-035 ASR, in=0xF0000000, num=4 -> out=0xFF000000, carry=0; LSL, in=0x80000001, num=1 -> out=0x00000002, carry=1.
REQ-036 ROR, in=0x00000001, num=1 -> out=0x80000000, carry=1; any op with num=0, in=0x1234ABCD -> out=0x1234ABCD, carry=0.
REQ-037 LSR, in=0x0000000F, num=4 -> out=0x00000000, carry=1, zero=1.
REQ-038 Back-to-back 8 ops with out_ready=0 from cycle 3 for 4 cycles -> in_ready falls after 2 accepts, out holds, all 8 results emerge in order with none lost or duplicated.
REQ-039 rst_n pulsed low with both stages full -> out_valid=0, out=0 at once; no stale result after release.
